// File: rtl/rsp_pkg.sv
// Shared definitions for the rock-scissor-paper round judge.
// Choice/result codes, FSM encodings and the seven-segment digit decode.
package rsp_pkg;

    localparam logic [2:0] ROCK    = 3'b001;
    localparam logic [2:0] SCISSOR = 3'b010;
    localparam logic [2:0] PAPER   = 3'b100;

    typedef enum logic [1:0] {
        RES_NONE = 2'b00,
        RES_WIN  = 2'b01,
        RES_LOSE = 2'b10,
        RES_DRAW = 2'b11
    } res_e;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_SETTLE = 3'd1;
    localparam logic [2:0] ST_JUDGE  = 3'd2;
    localparam logic [2:0] ST_SHOW   = 3'd3;
    localparam logic [2:0] ST_OVER   = 3'd4;

    function automatic logic is_choice(input logic [2:0] c);
        return (c == ROCK) || (c == SCISSOR) || (c == PAPER);
    endfunction

    function automatic res_e judge(input logic [2:0] u, input logic [2:0] c);
        if (u == c)
            return RES_DRAW;
        if ((u == ROCK && c == SCISSOR) ||
            (u == SCISSOR && c == PAPER) ||
            (u == PAPER && c == ROCK))
            return RES_WIN;
        return RES_LOSE;
    endfunction

    // Active-high gfedcba; anything above 9 shows 'E'.
    function automatic logic [6:0] seg7(input logic [7:0] v);
        logic [6:0] s;
        case (v)
            8'd0:    s = 7'h3F;
            8'd1:    s = 7'h06;
            8'd2:    s = 7'h5B;
            8'd3:    s = 7'h4F;
            8'd4:    s = 7'h66;
            8'd5:    s = 7'h6D;
            8'd6:    s = 7'h7D;
            8'd7:    s = 7'h07;
            8'd8:    s = 7'h7F;
            8'd9:    s = 7'h6F;
            default: s = 7'h79;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/rsp_judge_if.sv
// Bundle between the keypad/random stage, the judge and the display.
// RSP_SEG7_EN adds the seven-segment score outputs.
interface rsp_judge_if #(
    parameter int SCORE_W = 4
);
    logic               key_press;
    logic [2:0]         user_sel;
    logic [2:0]         cpu_sel;
    logic [1:0]         result;
    logic               result_valid;
    logic               sel_err;
    logic               led_win;
    logic               led_lose;
    logic               led_draw;
    logic [SCORE_W-1:0] user_score;
    logic [SCORE_W-1:0] cpu_score;
    logic               game_over;
`ifdef RSP_SEG7_EN
    logic [6:0]         seg_user;
    logic [6:0]         seg_cpu;
`endif

    modport master (
        output key_press, user_sel, cpu_sel,
        input  result, result_valid, sel_err,
        input  led_win, led_lose, led_draw,
        input  user_score, cpu_score, game_over
`ifdef RSP_SEG7_EN
        , input seg_user, seg_cpu
`endif
    );

    modport slave (
        input  key_press, user_sel, cpu_sel,
        output result, result_valid, sel_err,
        output led_win, led_lose, led_draw,
        output user_score, cpu_score, game_over
`ifdef RSP_SEG7_EN
        , output seg_user, seg_cpu
`endif
    );

endinterface

// File: rtl/rsp_press_sync.sv
// Two-flop synchroniser for the keypad level plus a registered rising-edge pulse.
module rsp_press_sync (
    input  logic CLK,
    input  logic RESET,
    input  logic din,
    output logic level,
    output logic pulse
);

    logic s1;
    logic s2;
    logic s3;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            s1    <= 1'b0;
            s2    <= 1'b0;
            s3    <= 1'b0;
            pulse <= 1'b0;
        end else begin
            s1    <= din;
            s2    <= s1;
            s3    <= s2;
            pulse <= s2 & ~s3;
        end
    end

    assign level = s2;

endmodule

// File: rtl/rsp_judge.sv
// Round judge: settle after a press, decide win/lose/draw, keep scores, hold LEDs.
// RSP_SEG7_EN enables the seven-segment score decoders.
module rsp_judge
    import rsp_pkg::*;
#(
    parameter int SETTLE_CYCLES = 1300,
    parameter int SHOW_CYCLES   = 50000,
    parameter int SCORE_W       = 4,
    parameter int WIN_SCORE     = 3
) (
    input logic         CLK,
    input logic         RESET,
    rsp_judge_if.slave  bus
);

    localparam int TMAX = (SHOW_CYCLES > SETTLE_CYCLES) ? SHOW_CYCLES : SETTLE_CYCLES;
    localparam int TW   = $clog2(TMAX + 1);

    localparam logic [TW-1:0]      SETTLE_LAST = TW'(SETTLE_CYCLES - 1);
    localparam logic [TW-1:0]      SHOW_END    = TW'(SHOW_CYCLES);
    localparam logic [SCORE_W-1:0] WIN_LAST    = SCORE_W'(WIN_SCORE - 1);
    localparam logic [SCORE_W-1:0] WIN_FULL    = SCORE_W'(WIN_SCORE);

    logic               key_level;
    logic               press;
    logic [2:0]         state;
    logic [TW-1:0]      timer;
    res_e               res_q;
    logic               valid_q;
    logic               err_q;
    logic               win_q;
    logic               lose_q;
    logic               draw_q;
    logic [SCORE_W-1:0] user_q;
    logic [SCORE_W-1:0] cpu_q;

    logic sel_ok;
    res_e verdict;
    logic user_inc;
    logic cpu_inc;
    logic match_end;

    rsp_press_sync u_sync (
        .CLK   (CLK),
        .RESET (RESET),
        .din   (bus.key_press),
        .level (key_level),
        .pulse (press)
    );

    always_comb begin
        sel_ok    = is_choice(bus.user_sel) && is_choice(bus.cpu_sel);
        verdict   = judge(bus.user_sel, bus.cpu_sel);
        user_inc  = sel_ok && (verdict == RES_WIN);
        cpu_inc   = sel_ok && (verdict == RES_LOSE);
        match_end = (user_inc && user_q == WIN_LAST) ||
                    (cpu_inc && cpu_q == WIN_LAST);
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state   <= ST_IDLE;
            timer   <= '0;
            res_q   <= RES_NONE;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
            win_q   <= 1'b0;
            lose_q  <= 1'b0;
            draw_q  <= 1'b0;
            user_q  <= '0;
            cpu_q   <= '0;
        end else begin
            valid_q <= 1'b0;
            err_q   <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (press) begin
                        state <= ST_SETTLE;
                        timer <= SETTLE_LAST;
                    end
                end
                ST_SETTLE: begin
                    if (timer == '0)
                        state <= ST_JUDGE;
                    else
                        timer <= timer - 1'b1;
                end
                ST_JUDGE: begin
                    timer   <= '0;
                    valid_q <= 1'b1;
                    if (!sel_ok) begin
                        err_q <= 1'b1;
                        res_q <= RES_NONE;
                        state <= ST_SHOW;
                    end else begin
                        res_q  <= verdict;
                        win_q  <= (verdict == RES_WIN);
                        lose_q <= (verdict == RES_LOSE);
                        draw_q <= (verdict == RES_DRAW);
                        user_q <= user_q + SCORE_W'(user_inc);
                        cpu_q  <= cpu_q + SCORE_W'(cpu_inc);
                        state  <= match_end ? ST_OVER : ST_SHOW;
                    end
                end
                ST_SHOW: begin
                    if (timer != SHOW_END)
                        timer <= timer + 1'b1;
                    // Holding the key keeps the LEDs up; a new round needs a fresh edge.
                    if (timer == SHOW_END && !key_level) begin
                        win_q  <= 1'b0;
                        lose_q <= 1'b0;
                        draw_q <= 1'b0;
                        state  <= ST_IDLE;
                    end
                end
                ST_OVER: begin
                    if (press) begin
                        res_q  <= RES_NONE;
                        win_q  <= 1'b0;
                        lose_q <= 1'b0;
                        draw_q <= 1'b0;
                        user_q <= '0;
                        cpu_q  <= '0;
                        state  <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.result       = res_q;
    assign bus.result_valid = valid_q;
    assign bus.sel_err      = err_q;
    assign bus.led_win      = win_q;
    assign bus.led_lose     = lose_q;
    assign bus.led_draw     = draw_q;
    assign bus.user_score   = user_q;
    assign bus.cpu_score    = cpu_q;
    assign bus.game_over    = (user_q == WIN_FULL) || (cpu_q == WIN_FULL);

`ifdef RSP_SEG7_EN
    assign bus.seg_user = seg7(8'(user_q));
    assign bus.seg_cpu  = seg7(8'(cpu_q));
`endif

endmodule
